// File: rtl/threefish256_round_ctrl.sv
// Iterative Threefish-256 encryption core: two MIX lanes run one round per clock.
// A subkey is injected after every fourth round, and the result lands in ct after round 71.
module threefish256_mix (
  input  logic [63:0] x0,
  input  logic [63:0] x1,
  input  logic        rj,
  input  logic [2:0]  rd,
  output logic [63:0] y0,
  output logic [63:0] y1
);
  logic [5:0]   amt;
  logic [127:0] dbl;

  always_comb begin
    amt = 6'd32;
    case ({rd, rj})
      4'h0: amt = 6'd14;  4'h1: amt = 6'd16;
      4'h2: amt = 6'd52;  4'h3: amt = 6'd57;
      4'h4: amt = 6'd23;  4'h5: amt = 6'd40;
      4'h6: amt = 6'd5;   4'h7: amt = 6'd37;
      4'h8: amt = 6'd25;  4'h9: amt = 6'd33;
      4'ha: amt = 6'd46;  4'hb: amt = 6'd12;
      4'hc: amt = 6'd58;  4'hd: amt = 6'd22;
      default: amt = 6'd32;
    endcase
  end

  // Shifting the doubled word left puts rotl(x1, amt) in the upper half.
  assign dbl = {x1, x1} << amt;
  assign y0  = x0 + x1;
  assign y1  = dbl[127:64] ^ y0;
endmodule

module threefish256_round_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [127:0] tweak,
  input  logic [255:0] pt,
  output logic         ready,
  output logic         done,
  output logic [255:0] ct
);
  localparam int          NUM_LANES = 2;
  localparam logic [63:0] C240      = 64'h1BD11BDAA9FC1A22;

  typedef enum logic {IDLE, RUN} st_t;

  st_t                          st, st_n;
  logic [6:0]                   r, r_n;
  logic [4:0]                   s, s_n;
  logic [4:0][63:0]             k;
  logic [2:0][63:0]             t;
  logic [3:0][63:0]             w, w_n, perm, sk, sk0, nw, keyw, ptw;
  logic [1:0][63:0]             tww;
  logic [255:0]                 ct_n;
  logic                         done_n, ld, inj;
  logic [2:0]                   rd;
  logic [NUM_LANES-1:0]         rj;
  logic [NUM_LANES-1:0][63:0]   x0, x1, y0, y1;

  function automatic logic [2:0] mod5(input logic [4:0] v);
    logic [4:0] m;
    m = v % 5'd5;
    return m[2:0];
  endfunction

  function automatic logic [1:0] mod3(input logic [4:0] v);
    logic [4:0] m;
    m = v % 5'd3;
    return m[1:0];
  endfunction

  assign keyw  = key;
  assign ptw   = pt;
  assign tww   = tweak;
  assign rd    = r[2:0];
  assign ready = (st == IDLE);

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_mix
      assign rj[g] = (g == 1);
      assign x0[g] = w[2*g];
      assign x1[g] = w[2*g+1];
      threefish256_mix u_mix (
        .x0(x0[g]), .x1(x1[g]), .rj(rj[g]), .rd(rd), .y0(y0[g]), .y1(y1[g])
      );
    end
  endgenerate

  // Word permutation: {w0,w1,w2,w3} <= {A.y0, B.y1, B.y0, A.y1}.
  assign perm = {y1[0], y0[1], y1[1], y0[0]};
  assign inj  = (r[1:0] == 2'd3);

  // Subkeys come only from registered k, t and s, which keeps input paths out of the round logic.
  always_comb begin
    sk[0] = k[mod5(s)];
    sk[1] = k[mod5(s + 5'd1)] + t[mod3(s)];
    sk[2] = k[mod5(s + 5'd2)] + t[mod3(s + 5'd1)];
    sk[3] = k[mod5(s + 5'd3)] + {59'd0, s};
  end

  always_comb begin
    sk0[0] = keyw[0];
    sk0[1] = keyw[1] + tww[0];
    sk0[2] = keyw[2] + tww[1];
    sk0[3] = keyw[3];
  end

  always_comb begin
    for (int i = 0; i < 4; i++) nw[i] = perm[i] + (inj ? sk[i] : 64'd0);
  end

  always_comb begin
    st_n   = st;
    w_n    = w;
    r_n    = r;
    s_n    = s;
    ct_n   = ct;
    done_n = 1'b0;
    ld     = 1'b0;
    case (st)
      IDLE: begin
        if (start) begin
          ld   = 1'b1;
          for (int i = 0; i < 4; i++) w_n[i] = ptw[i] + sk0[i];
          r_n  = 7'd0;
          s_n  = 5'd1;
          st_n = RUN;
        end
      end
      RUN: begin
        w_n = nw;
        r_n = r + 7'd1;
        if (inj) s_n = s + 5'd1;
        if (r == 7'd71) begin
          ct_n   = nw;
          done_n = 1'b1;
          st_n   = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      r    <= '0;
      s    <= '0;
      k    <= '0;
      t    <= '0;
      w    <= '0;
      ct   <= '0;
      done <= 1'b0;
    end else begin
      st   <= st_n;
      r    <= r_n;
      s    <= s_n;
      w    <= w_n;
      ct   <= ct_n;
      done <= done_n;
      if (ld) begin
        k[3:0] <= keyw;
        k[4]   <= C240 ^ keyw[0] ^ keyw[1] ^ keyw[2] ^ keyw[3];
        t      <= {tww[0] ^ tww[1], tww[1], tww[0]};
      end
    end
  end
endmodule
